// File: rtl/sram_bus_ctrl.sv
// Arbitrates openmips instruction-fetch and data requests onto one asynchronous SRAM port.
// Optional one-entry fetch buffer enabled by defining SRAM_FETCH_BUFFER_EN.
module sram_bus_ctrl #(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stall_o,
  inout  wire  [31:0] sram_data,
  output logic [19:0] sram_addr,
  output logic [3:0]  sram_be_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam int CNT_W = (READ_WAIT < 1) ? 1 : $clog2(READ_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE, MEM_RD, MEM_WS, MEM_WP, MEM_WH, IF_RD, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             rd_last;
  logic [19:0]      addr_q;
  logic             bus_drive;
  logic             fetch_hit;
  logic             unused_addr;

  assign unused_addr = ^{if_addr_i[31:22], if_addr_i[1:0], mem_addr_i[31:22], mem_addr_i[1:0]};
  assign rd_last     = (cnt == CNT_W'(READ_WAIT));
  assign stall_o     = (if_ce_i | mem_ce_i) & (state != DONE) & ~rst;
  assign sram_data   = bus_drive ? mem_data_i : 32'bz;

`ifdef SRAM_FETCH_BUFFER_EN
  logic        fb_valid;
  logic [19:0] fb_tag;
  logic [31:0] fb_data;

  assign fetch_hit = fb_valid & (if_addr_i[21:2] == fb_tag);

  // Buffer is invalidated by any write pulse that lands on the cached word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_valid <= 1'b0;
      fb_tag   <= '0;
      fb_data  <= '0;
    end else if (state == IF_RD && rd_last) begin
      fb_valid <= 1'b1;
      fb_tag   <= if_addr_i[21:2];
      fb_data  <= sram_data;
    end else if (state == MEM_WP && mem_addr_i[21:2] == fb_tag) begin
      fb_valid <= 1'b0;
    end
  end
`else
  assign fetch_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_ce_i)
          state_nxt = mem_we_i ? MEM_WS : MEM_RD;
        else if (if_ce_i)
          state_nxt = fetch_hit ? DONE : IF_RD;
      end
      MEM_RD:  if (rd_last) state_nxt = if_ce_i ? IF_RD : DONE;
      MEM_WS:  state_nxt = MEM_WP;
      MEM_WP:  state_nxt = MEM_WH;
      MEM_WH:  state_nxt = if_ce_i ? IF_RD : DONE;
      IF_RD:   if (rd_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset releases the bus at once.
  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_be_n = 4'hF;
    sram_addr = addr_q;
    bus_drive = 1'b0;
    case (state)
      MEM_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = ~mem_sel_i;
        sram_addr = mem_addr_i[21:2];
      end
      MEM_WS, MEM_WP, MEM_WH: begin
        sram_ce_n = 1'b0;
        sram_we_n = (state != MEM_WP);
        sram_be_n = ~mem_sel_i;
        sram_addr = mem_addr_i[21:2];
        bus_drive = 1'b1;
      end
      IF_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = 4'h0;
        sram_addr = if_addr_i[21:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      if_data_o  <= '0;
      mem_data_o <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= sram_addr;
      if ((state == MEM_RD || state == IF_RD) && !rd_last)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (state == MEM_RD && rd_last)
        mem_data_o <= sram_data;
      if (state == IF_RD && rd_last)
        if_data_o <= sram_data;
`ifdef SRAM_FETCH_BUFFER_EN
      if (state == IDLE && if_ce_i && !mem_ce_i && fetch_hit)
        if_data_o <= fb_data;
`endif
    end
  end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl with a behavioural asynchronous SRAM on the shared bus.
module tb_sram_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i, mem_ce_i, mem_we_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] if_data_o, mem_data_o;
  logic        stall_o;
  wire  [31:0] sram_data;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  logic [31:0] sram_mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

  int          stall_cyc, ce_cyc, oe_cyc, we_cyc, drv_cyc;
  logic [31:0] be_we, addr_we, data_we, addr_rd;

  always #5 clk = ~clk;

  sram_bus_ctrl #(.READ_WAIT(1)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .stall_o(stall_o), .sram_data(sram_data), .sram_addr(sram_addr),
    .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 32'bz;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr[9:0]][b*8 +: 8] <= sram_data[b*8 +: 8];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Samples one transaction per negedge until stall drops (the DONE cycle).
  task automatic run_req();
    bit done = 0;
    stall_cyc = 0; ce_cyc = 0; oe_cyc = 0; we_cyc = 0; drv_cyc = 0;
    be_we = '1; addr_we = '1; data_we = '1; addr_rd = '1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!sram_ce_n) ce_cyc++;
      if (!sram_oe_n) oe_cyc++;
      if (dut.bus_drive) drv_cyc++;
      if (!sram_ce_n && !sram_oe_n && addr_rd == '1) addr_rd = {12'h0, sram_addr};
      if (!sram_we_n) begin
        we_cyc++;
        be_we   = {28'h0, sram_be_n};
        addr_we = {12'h0, sram_addr};
        data_we = sram_data;
      end
      if (stall_o) stall_cyc++;
      else done = 1;
    end
    if (!done) check_val("timeout", 32'd1, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
    sram_mem[0]    = 32'h3C01_0000;
    sram_mem[1]    = 32'h3421_0001;
    sram_mem[4]    = 32'h2402_0005;
    sram_mem[8]    = 32'h8C22_0008;
    sram_mem[9'h40] = 32'h1122_3344;
    sram_mem[9'h80] = 32'hDEAD_BEEF;
    sram_mem[10'hC0] = 32'h5555_5555;

    rst = 1'b1;
    if_ce_i = 1'b1; if_addr_i = 32'h10;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = 4'h0; mem_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ce_n",  {31'h0, sram_ce_n}, 32'd1);
    check_val("rst_oe_we", {30'h0, sram_oe_n, sram_we_n}, 32'd3);
    check_val("rst_be_n",  {28'h0, sram_be_n}, 32'hF);
    check_val("rst_addr",  {12'h0, sram_addr}, 32'h0);
    check_val("rst_drive", {31'h0, dut.bus_drive}, 32'd0);
    check_val("rst_data",  if_data_o | mem_data_o, 32'h0);
    check_val("rst_stall", {31'h0, stall_o}, 32'd0);
    if_ce_i = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Plain fetch of word 4.
    if_ce_i = 1'b1; if_addr_i = 32'h10;
    run_req();
    check_val("f_stall", stall_cyc, 3);
    check_val("f_addr",  addr_rd, 32'h4);
    check_val("f_ce",    ce_cyc, 2);
    check_val("f_data",  if_data_o, 32'h2402_0005);
    next_cycle();

    // Back-to-back fetches: first stall-high sample of the second proves a single low cycle.
    if_addr_i = 32'h0;
    run_req();
    check_val("bb0_stall", stall_cyc, 3);
    check_val("bb0_data",  if_data_o, 32'h3C01_0000);
    next_cycle();
    if_addr_i = 32'h4;
    run_req();
    check_val("bb1_stall", stall_cyc, 3);
    check_val("bb1_addr",  addr_rd, 32'h1);
    check_val("bb1_data",  if_data_o, 32'h3421_0001);
    next_cycle();

    // Byte write plus fetch: write goes first.
    if_addr_i = 32'h0;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h100; mem_sel_i = 4'b0001;
    mem_data_i = 32'h0000_00AB;
    run_req();
    check_val("wf_stall", stall_cyc, 6);
    check_val("wf_we",    we_cyc, 1);
    check_val("wf_be",    be_we, 32'hE);
    check_val("wf_addr",  addr_we, 32'h40);
    check_val("wf_bus",   data_we, 32'h0000_00AB);
    check_val("wf_drv",   drv_cyc, 3);
    check_val("wf_mem",   sram_mem[9'h40], 32'h1122_33AB);
    check_val("wf_fetch", if_data_o, 32'h3C01_0000);
    next_cycle();

    // Data read only.
    if_ce_i = 1'b0;
    mem_we_i = 1'b0; mem_addr_i = 32'h200; mem_sel_i = 4'hF;
    run_req();
    check_val("rd_stall", stall_cyc, 3);
    check_val("rd_oe",    oe_cyc, 2);
    check_val("rd_drv",   drv_cyc, 0);
    check_val("rd_addr",  addr_rd, 32'h80);
    check_val("rd_data",  mem_data_o, 32'hDEAD_BEEF);
    next_cycle();

    // Repeated fetch of 0x20, then overwrite it and fetch again.
    mem_ce_i = 1'b0;
    if_ce_i = 1'b1; if_addr_i = 32'h20;
    run_req();
    check_val("fb0_stall", stall_cyc, 3);
    check_val("fb0_data",  if_data_o, 32'h8C22_0008);
    next_cycle();
    run_req();
`ifdef SRAM_FETCH_BUFFER_EN
    check_val("fb1_stall", stall_cyc, 1);
    check_val("fb1_ce",    ce_cyc, 0);
`else
    check_val("fb1_stall", stall_cyc, 3);
    check_val("fb1_ce",    ce_cyc, 2);
`endif
    check_val("fb1_data",  if_data_o, 32'h8C22_0008);
    next_cycle();
    if_ce_i = 1'b0;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h20; mem_sel_i = 4'hF;
    mem_data_i = 32'h1234_5678;
    run_req();
    check_val("fbw_stall", stall_cyc, 4);
    check_val("fbw_mem",   sram_mem[8], 32'h1234_5678);
    next_cycle();
    mem_ce_i = 1'b0;
    if_ce_i = 1'b1;
    run_req();
    check_val("fb2_stall", stall_cyc, 3);
    check_val("fb2_ce",    ce_cyc, 2);
    check_val("fb2_data",  if_data_o, 32'h1234_5678);
    next_cycle();

    // Reset asserted in the middle of the write pulse.
    if_ce_i = 1'b0;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
    mem_data_i = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    check_val("wp_we_low", {31'h0, sram_we_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_val("ar_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    check_val("ar_be_n",    {28'h0, sram_be_n}, 32'hF);
    check_val("ar_drive",   {31'h0, dut.bus_drive}, 32'd0);
    check_val("ar_stall",   {31'h0, stall_o}, 32'd0);
    next_cycle();
    check_val("ar_mem",     sram_mem[10'hC0], 32'h5555_5555);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    rst = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
